clk_div_cfg_ctrl: RTL and testbench
===================================

Name: clk_div_cfg_ctrl

Overview:
Configuration sequencer for the ClkDiv clock divider. It drives ClkDiv's clock enable and division ratio.
- Accepts ratio/enable change requests over a valid/ready handshake.
- For every change: gates the divider off, waits a settle window, loads the new ratio, re-enables, then waits one full divided period before reporting done.
- Sits between the register file / power manager and the ClkDiv instance, so software never changes ClkDiv's division ratio input while the divider is running.

Parameters:
RATIO_W, 5, width of ratio fields; matches ClkDiv ratio input.
SETTLE_CYC, 4, ref-clock cycles the enable is held low before the new ratio is loaded; legal range 1..15.
DEFAULT_RATIO, 1, o_div_ratio value after reset.

Ports:
i_ref_clk  in  1  reference clock; same clock as ClkDiv.
i_rst_n  in  1  reset, asynchronous, active-low.
i_req_valid  in  1  configuration request valid.
i_req_ratio  in  RATIO_W  requested division ratio.
i_req_en  in  1  requested divider enable.
o_req_ready  out  1  controller idle; request accepted on valid&ready at rising edge.
o_div_ratio  out  RATIO_W  ratio to ClkDiv; registered.
o_clk_en  out  1  enable to ClkDiv; registered.
o_busy  out  1  high in any state other than IDLE.
o_done  out  1  one-cycle pulse; the request has been fully applied.

Behaviour:
Reset (async, i_rst_n=0):
- State IDLE.
- o_div_ratio=DEFAULT_RATIO, o_clk_en=0, o_done=0.
- Settle and lock counters cleared.
- o_req_ready=1 and o_busy=0 from reset onward.

Ready and busy:
- o_req_ready = (state==IDLE), combinational from the state register.
- o_busy = !o_req_ready.

Request capture:
- Shadow registers capture ratio/en on valid&ready.
- Requests while busy are ignored; they are not queued.
- The requester holds valid until ready.

FSM states: IDLE, GATE, LOAD, LOCK, DONE.
- IDLE:
  - On accept at edge T with i_req_ratio==o_div_ratio and i_req_en==o_clk_en: go to DONE. No change on any divider output.
  - Otherwise: go to GATE, clear o_clk_en at edge T, clear the settle counter.
- GATE:
  - o_clk_en held 0; the settle counter increments each cycle.
  - After SETTLE_CYC cycles in GATE (edge T+SETTLE_CYC): o_div_ratio<=shadow ratio, go to LOAD.
- LOAD (one cycle):
  - If shadow en=1: o_clk_en<=1 at edge T+SETTLE_CYC+1, load the lock counter, go to LOCK.
  - If shadow en=0: go to DONE, o_clk_en stays 0.
- LOCK:
  - Wait L cycles, where L = shadow ratio if ratio>=2, else L=1 (ClkDiv bypasses for ratio 0/1).
  - Then go to DONE.
- DONE:
  - o_done=1 for exactly one cycle, then return to IDLE.
  - o_done is a registered output: asserted for the cycle following the DONE-entry edge.

Latency from accept edge T to the o_done-asserting edge:
- Same config: T+1.
- Disable request: T+SETTLE_CYC+2.
- Enable request: T+SETTLE_CYC+2+L.
- o_req_ready returns one edge after o_done is asserted.

Other rules:
- Ratio 0 is accepted and treated like 1 (bypass). No error is signalled.
- The lock counter is RATIO_W bits wide. The settle counter is 4 bits.
- Counters never wrap: they saturate and clear on every state entry.
- o_div_ratio changes only at the GATE->LOAD edge, and never while o_clk_en=1.
- Async reset mid-sequence (any state): all outputs return to reset values immediately. A pending request is discarded, not resumed.
- Requests with a changed ratio and i_req_en=0 still run GATE and LOAD, so the stored ratio is updated.

Test Plan:
1. Reset with defaults, no request: o_div_ratio=1, o_clk_en=0, o_req_ready=1, o_busy=0, o_done=0.
2. Accept ratio=6, en=1 at edge 0:
   - o_clk_en=0 through edge 4; o_div_ratio=6 at edge 4.
   - o_clk_en=1 at edge 5; o_done pulse at edge 12; o_req_ready=1 at edge 13.
3. From state ratio=6, en=1, request ratio=6, en=1 at edge 0: o_done at edge 1; o_clk_en stays 1 and o_div_ratio stays 6 throughout.
4. From ratio=6, en=1, request ratio=3, en=0: o_clk_en falls at accept edge; o_div_ratio=3 after 4 cycles; o_done at T+6; o_clk_en remains 0.
5. Hold i_req_valid with ratio=9 during a busy sequence: not accepted; the first sequence completes unchanged. The request is accepted on the first IDLE cycle and yields o_div_ratio=9.
6. Assert i_rst_n=0 during LOCK of a ratio=7 request: outputs go immediately to ratio=1, en=0, ready=1. After release, no o_done pulse appears.

Source files
------------

// File: rtl/clk_div_cfg_ctrl_if.sv
// ---------------------------------------------------------------------------
// clk_div_cfg_ctrl_if
//
// Purpose:
//   Bundles the configuration request handshake and the divider control
//   outputs of clk_div_cfg_ctrl. The requester side (register file or power
//   manager) uses the master modport. The controller uses the slave modport.
//
// Signals:
//   i_req_valid  requester -> ctrl  configuration request valid
//   i_req_ratio  requester -> ctrl  requested division ratio (RATIO_W bits)
//   i_req_en     requester -> ctrl  requested divider enable
//   o_req_ready  ctrl -> requester  controller idle, request accepted on valid&ready
//   o_div_ratio  ctrl -> ClkDiv     registered division ratio (RATIO_W bits)
//   o_clk_en     ctrl -> ClkDiv     registered divider enable
//   o_busy       ctrl -> requester  controller is sequencing a change
//   o_done       ctrl -> requester  one-cycle pulse, request fully applied
// ---------------------------------------------------------------------------
interface clk_div_cfg_ctrl_if #(
    parameter int RATIO_W = 5
);
    logic               i_req_valid;
    logic [RATIO_W-1:0] i_req_ratio;
    logic               i_req_en;
    logic               o_req_ready;
    logic [RATIO_W-1:0] o_div_ratio;
    logic               o_clk_en;
    logic               o_busy;
    logic               o_done;

    modport master (
        output i_req_valid,
        output i_req_ratio,
        output i_req_en,
        input  o_req_ready,
        input  o_div_ratio,
        input  o_clk_en,
        input  o_busy,
        input  o_done
    );

    modport slave (
        input  i_req_valid,
        input  i_req_ratio,
        input  i_req_en,
        output o_req_ready,
        output o_div_ratio,
        output o_clk_en,
        output o_busy,
        output o_done
    );
endinterface

// File: rtl/clk_div_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// clk_div_cfg_ctrl
//
// Purpose:
//   Configuration sequencer for the ClkDiv clock divider. Every accepted
//   ratio/enable change is applied as: gate the divider off, wait a settle
//   window, load the new ratio, re-enable (if requested), wait one full
//   divided period, then pulse done. The ratio seen by ClkDiv therefore
//   never changes while the divider is enabled.
//
// Parameters:
//   RATIO_W        width of the ratio fields (matches ClkDiv ratio input)
//   SETTLE_CYC     ref-clock cycles the enable is held low before loading
//                  the new ratio, legal range 1..15
//   DEFAULT_RATIO  o_div_ratio value after reset
//
// Ports:
//   i_ref_clk  reference clock, same clock as ClkDiv
//   i_rst_n    asynchronous active-low reset
//   cfg        slave side of clk_div_cfg_ctrl_if (request handshake and
//              divider control outputs)
// ---------------------------------------------------------------------------
module clk_div_cfg_ctrl #(
    parameter int RATIO_W       = 5,
    parameter int SETTLE_CYC    = 4,
    parameter int DEFAULT_RATIO = 1
) (
    input  logic              i_ref_clk,
    input  logic              i_rst_n,
    clk_div_cfg_ctrl_if.slave cfg
);

    // Elaboration-time guard on the settle window: the settle counter is
    // four bits wide and a zero-length window would skip the gate phase.
    if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
        $error("clk_div_cfg_ctrl: SETTLE_CYC must be in 1..15");
    end

    localparam logic [RATIO_W-1:0] RESET_RATIO = RATIO_W'(DEFAULT_RATIO);
    localparam logic [3:0]         SETTLE_LAST = 4'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        GATE,
        LOAD,
        LOCK,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [RATIO_W-1:0] div_ratio;
    logic [RATIO_W-1:0] div_ratio_nxt;
    logic               clk_en;
    logic               clk_en_nxt;
    logic               done;
    logic               done_nxt;
    logic [3:0]         settle_cnt;
    logic [3:0]         settle_cnt_nxt;
    logic [RATIO_W-1:0] lock_cnt;
    logic [RATIO_W-1:0] lock_cnt_nxt;
    logic [RATIO_W-1:0] sh_ratio;
    logic [RATIO_W-1:0] sh_ratio_nxt;
    logic               sh_en;
    logic               sh_en_nxt;

    logic               accept;
    logic               same_cfg;

    // Lock window length: ClkDiv bypasses for ratios 0 and 1, so one
    // reference cycle covers a full output period in that case.
    function automatic logic [RATIO_W-1:0] lock_len(input logic [RATIO_W-1:0] r);
        return (r >= RATIO_W'(2)) ? r : RATIO_W'(1);
    endfunction

    // Saturating increment for the settle counter.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Saturating decrement for the lock counter (holds at zero).
    function automatic logic [RATIO_W-1:0] sat_dec(input logic [RATIO_W-1:0] v);
        return (v == '0) ? v : v - RATIO_W'(1);
    endfunction

    assign accept   = cfg.i_req_valid && (state == IDLE);
    assign same_cfg = (cfg.i_req_ratio == div_ratio) && (cfg.i_req_en == clk_en);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        div_ratio_nxt  = div_ratio;
        clk_en_nxt     = clk_en;
        done_nxt       = 1'b0;
        settle_cnt_nxt = settle_cnt;
        lock_cnt_nxt   = lock_cnt;
        sh_ratio_nxt   = sh_ratio;
        sh_en_nxt      = sh_en;

        case (state)
            IDLE: begin
                settle_cnt_nxt = '0;
                lock_cnt_nxt   = '0;
                if (accept) begin
                    sh_ratio_nxt = cfg.i_req_ratio;
                    sh_en_nxt    = cfg.i_req_en;
                    if (same_cfg) begin
                        // Nothing to change on the divider, just acknowledge.
                        state_nxt = DONE;
                    end else begin
                        state_nxt  = GATE;
                        clk_en_nxt = 1'b0;
                    end
                end
            end

            GATE: begin
                clk_en_nxt = 1'b0;
                if (settle_cnt >= SETTLE_LAST) begin
                    // Divider has been gated for SETTLE_CYC cycles: safe to
                    // present the new ratio.
                    div_ratio_nxt  = sh_ratio;
                    settle_cnt_nxt = '0;
                    state_nxt      = LOAD;
                end else begin
                    settle_cnt_nxt = sat_inc4(settle_cnt);
                end
            end

            LOAD: begin
                if (sh_en) begin
                    clk_en_nxt   = 1'b1;
                    lock_cnt_nxt = lock_len(sh_ratio);
                    state_nxt    = LOCK;
                end else begin
                    state_nxt    = DONE;
                end
            end

            LOCK: begin
                // Counts down from L; leaving on the edge where it reads 1
                // gives exactly L cycles in this state.
                if (lock_cnt <= RATIO_W'(1)) begin
                    lock_cnt_nxt = '0;
                    state_nxt    = DONE;
                end else begin
                    lock_cnt_nxt = sat_dec(lock_cnt);
                end
            end

            DONE: begin
                // First cycle raises the registered done pulse, second cycle
                // (with the pulse visible) drops it and returns to IDLE.
                settle_cnt_nxt = '0;
                lock_cnt_nxt   = '0;
                if (!done) begin
                    done_nxt = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt  = IDLE;
                clk_en_nxt = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registered outputs, counters and request shadow
    // -----------------------------------------------------------------------
    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_ratio  <= RESET_RATIO;
            clk_en     <= 1'b0;
            done       <= 1'b0;
            settle_cnt <= '0;
            lock_cnt   <= '0;
            sh_ratio   <= RESET_RATIO;
            sh_en      <= 1'b0;
        end else begin
            div_ratio  <= div_ratio_nxt;
            clk_en     <= clk_en_nxt;
            done       <= done_nxt;
            settle_cnt <= settle_cnt_nxt;
            lock_cnt   <= lock_cnt_nxt;
            sh_ratio   <= sh_ratio_nxt;
            sh_en      <= sh_en_nxt;
        end
    end

    assign cfg.o_req_ready = (state == IDLE);
    assign cfg.o_busy      = (state != IDLE);
    assign cfg.o_div_ratio = div_ratio;
    assign cfg.o_clk_en    = clk_en;
    assign cfg.o_done      = done;

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_div_cfg_ctrl
//
// Directed bench for clk_div_cfg_ctrl (RATIO_W=5, SETTLE_CYC=4,
// DEFAULT_RATIO=1). The stimulus process pushes the hand-computed result of
// every request (final ratio, final enable, edge of the done pulse) into a
// scoreboard queue; a monitor pops and compares on every o_done pulse.
// Edges are numbered by cyc, which counts rising clock edges.
// ---------------------------------------------------------------------------
module tb_clk_div_cfg_ctrl;

    localparam int RATIO_W    = 5;
    localparam int SETTLE_CYC = 4;

    typedef struct {
        logic [RATIO_W-1:0] ratio;
        logic               en;
        int                 edge_n;
        string              name;
    } exp_t;

    logic  clk   = 1'b0;
    logic  rst_n = 1'b0;
    int    cyc    = 0;
    int    checks = 0;
    int    errors = 0;
    exp_t  sb[$];
    exp_t  mon_e;

    clk_div_cfg_ctrl_if #(.RATIO_W(RATIO_W)) cfg ();

    clk_div_cfg_ctrl #(
        .RATIO_W      (RATIO_W),
        .SETTLE_CYC   (SETTLE_CYC),
        .DEFAULT_RATIO(1)
    ) dut (
        .i_ref_clk(clk),
        .i_rst_n  (rst_n),
        .cfg      (cfg.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every cycle with o_done high must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && cfg.o_done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got o_done=1 expected no pulse (edge %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_done_ratio"}, int'(cfg.o_div_ratio), int'(mon_e.ratio));
                check({mon_e.name, "_done_en"},    int'(cfg.o_clk_en),    int'(mon_e.en));
                check({mon_e.name, "_done_edge"},  cyc,                   mon_e.edge_n);
            end
        end
    end

    // Drive a request, hold valid until accepted, log the expectation.
    // Returns just after the accept edge with t_acc = accept edge index.
    task automatic send(input string name, input logic [RATIO_W-1:0] r, input logic en,
                        input logic [RATIO_W-1:0] er, input logic een, input int lat,
                        output int t_acc);
        int n;
        n = 0;
        @(negedge clk);
        cfg.i_req_valid = 1'b1;
        cfg.i_req_ratio = r;
        cfg.i_req_en    = en;
        while (cfg.o_req_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s_accept_timeout: got ready=%0b expected 1", name, cfg.o_req_ready);
        end
        @(posedge clk);
        #1;
        t_acc = cyc;
        sb.push_back('{ratio: er, en: een, edge_n: t_acc + lat, name: name});
        cfg.i_req_valid = 1'b0;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || cfg.o_req_ready !== 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL %s_idle_timeout: got pending=%0d expected 0", name, sb.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int t2;
        cfg.i_req_valid = 1'b0;
        cfg.i_req_ratio = '0;
        cfg.i_req_en    = 1'b0;

        // Reset defaults, during reset and after release.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ratio", int'(cfg.o_div_ratio), 1);
        check("rst_en",    int'(cfg.o_clk_en),    0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ratio", int'(cfg.o_div_ratio), 1);
        check("idle_en",    int'(cfg.o_clk_en),    0);
        check("idle_ready", int'(cfg.o_req_ready), 1);
        check("idle_busy",  int'(cfg.o_busy),      0);
        check("idle_done",  int'(cfg.o_done),      0);

        // ratio=6 en=1: L=6, done at T+4+2+6.
        send("en6", 5'd6, 1'b1, 5'd6, 1'b1, 12, t);
        check("en6_T_en", int'(cfg.o_clk_en), 0);
        wait_to(t + 1);
        check("en6_busy",  int'(cfg.o_busy),      1);
        check("en6_ready", int'(cfg.o_req_ready), 0);
        wait_to(t + 3);
        check("en6_T3_ratio", int'(cfg.o_div_ratio), 1);
        check("en6_T3_en",    int'(cfg.o_clk_en),    0);
        wait_to(t + 4);
        check("en6_T4_ratio", int'(cfg.o_div_ratio), 6);
        check("en6_T4_en",    int'(cfg.o_clk_en),    0);
        wait_to(t + 5);
        check("en6_T5_en", int'(cfg.o_clk_en), 1);
        wait_to(t + 12);
        check("en6_T12_ready", int'(cfg.o_req_ready), 0);
        wait_to(t + 13);
        check("en6_T13_ready", int'(cfg.o_req_ready), 1);
        wait_idle("en6");

        // Same configuration: done one edge after accept, no output change.
        send("same6", 5'd6, 1'b1, 5'd6, 1'b1, 1, t);
        check("same6_T_en", int'(cfg.o_clk_en), 1);
        wait_to(t + 1);
        check("same6_T1_en",    int'(cfg.o_clk_en),    1);
        check("same6_T1_ratio", int'(cfg.o_div_ratio), 6);
        wait_to(t + 2);
        check("same6_T2_ready", int'(cfg.o_req_ready), 1);
        check("same6_T2_ratio", int'(cfg.o_div_ratio), 6);
        wait_idle("same6");

        // Disable with new ratio: enable falls at accept, done at T+6.
        send("dis3", 5'd3, 1'b0, 5'd3, 1'b0, 6, t);
        check("dis3_T_en",    int'(cfg.o_clk_en),    0);
        check("dis3_T_ratio", int'(cfg.o_div_ratio), 6);
        wait_to(t + 3);
        check("dis3_T3_ratio", int'(cfg.o_div_ratio), 6);
        wait_to(t + 4);
        check("dis3_T4_ratio", int'(cfg.o_div_ratio), 3);
        wait_to(t + 7);
        check("dis3_T7_en", int'(cfg.o_clk_en), 0);
        wait_idle("dis3");

        // Request held during a busy sequence is taken on the first IDLE cycle.
        send("en2", 5'd2, 1'b1, 5'd2, 1'b1, 8, t);
        send("held9", 5'd9, 1'b1, 5'd9, 1'b1, 15, t2);
        check("held9_accept_edge", t2, t + 10);
        wait_idle("held9");
        check("held9_ratio", int'(cfg.o_div_ratio), 9);
        check("held9_en",    int'(cfg.o_clk_en),    1);

        // Ratio 0 is a bypass: one-cycle lock window.
        send("r0", 5'd0, 1'b1, 5'd0, 1'b1, 7, t);
        wait_idle("r0");
        send("r0same", 5'd0, 1'b1, 5'd0, 1'b1, 1, t);
        wait_idle("r0same");
        send("r0dis", 5'd0, 1'b0, 5'd0, 1'b0, 6, t);
        wait_idle("r0dis");

        // Async reset during LOCK of a ratio=7 request.
        send("rst7", 5'd7, 1'b1, 5'd7, 1'b1, 13, t);
        wait_to(t + 8);
        check("rst7_lock_en",    int'(cfg.o_clk_en),    1);
        check("rst7_lock_ratio", int'(cfg.o_div_ratio), 7);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst7_ratio", int'(cfg.o_div_ratio), 1);
        check("rst7_en",    int'(cfg.o_clk_en),    0);
        check("rst7_ready", int'(cfg.o_req_ready), 1);
        check("rst7_busy",  int'(cfg.o_busy),      0);
        check("rst7_done",  int'(cfg.o_done),      0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_ratio", int'(cfg.o_div_ratio), 1);
        check("post_rst_en",    int'(cfg.o_clk_en),    0);
        check("post_rst_ready", int'(cfg.o_req_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
